// File: rtl/cpu_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_seq_ctrl_pkg
// Shared definitions for the teaching-CPU sequencer: opcode values,
// instruction field bit positions, FSM state encoding and small opcode
// classification helpers.
// Instruction layout: [15:12] op, [11:8] rd, [7:4] rs1, [3:0] rs2, [7:0] imm8.
// ---------------------------------------------------------------------------
package cpu_seq_ctrl_pkg;

    // Opcodes; values 4'hA..4'hE are treated as NOP.
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_LDI  = 4'h6;
    localparam logic [3:0] OP_MOV  = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_BEQZ = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Instruction field bit positions
    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 8;
    localparam int RS1_HI = 7;
    localparam int RS1_LO = 4;
    localparam int RS2_HI = 3;
    localparam int RS2_LO = 0;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    // Sequencer states; ST_PAUSE is only reachable in the single-step build
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_READ   = 3'd3,
        ST_EXEC   = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_PAUSE  = 3'd7
    } state_e;

    // Opcodes that write rd back to the register file (ADD..MOV)
    function automatic logic op_writes_rd(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_MOV);
    endfunction

    // Opcodes whose result updates the zero flag (ADD..XOR)
    function automatic logic op_sets_zero(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_XOR);
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// ---------------------------------------------------------------------------
// cpu_alu
// Combinational ALU for the teaching CPU. Arithmetic wraps modulo 2^DATA_W
// with carry/borrow discarded.
// Ports:
//   op     in  4       opcode
//   a      in  DATA_W  source 1 operand
//   b      in  DATA_W  source 2 operand
//   imm8   in  8       immediate (LDI)
//   result out DATA_W  operation result (0 for non-ALU opcodes)
//   zero   out 1       result == 0
// ---------------------------------------------------------------------------
module cpu_alu
    import cpu_seq_ctrl_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [7:0]        imm8,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    // Operation select
    always_comb begin
        result = {DATA_W{1'b0}};
        case (op)
            OP_NOP:  result = {DATA_W{1'b0}};
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_LDI:  result = DATA_W'(imm8);
            OP_MOV:  result = a;
            default: result = {DATA_W{1'b0}};
        endcase
    end

    assign zero = (result == {DATA_W{1'b0}});

endmodule

// File: rtl/cpu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_seq_ctrl
// Multi-cycle control FSM for the 8-bit teaching CPU. Fetches a 16-bit
// instruction, strobes the register file read, executes through cpu_alu,
// strobes the write-back and updates the PC:
//   IDLE -> FETCH -> DECODE -> READ -> EXEC -> WB -> FETCH, plus HALT.
// Build option: define CPU_SINGLE_STEP_EN to add the 'step' input and a
// PAUSE state after WB that only advances to FETCH when step=1.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    begin execution from IDLE or HALT
//   step                     (CPU_SINGLE_STEP_EN only) leave PAUSE
//   imem_req/addr/ack/data   instruction fetch handshake (addr = pc)
//   rf_read_en, rf_write_en  one-cycle register file strobes
//   rf_read1/2_addr          source addresses (read1 = rd for BEQZ)
//   rf_write_addr/data       destination address and write-back value
//   rf_read1/2_data          register file read data (valid in EXEC)
//   pc, busy, halted         program counter and status
//   zero_flag                last ADD..XOR result was zero
// All outputs are registered.
// ---------------------------------------------------------------------------
module cpu_seq_ctrl
    import cpu_seq_ctrl_pkg::*;
#(
    parameter int              PC_W    = 8,
    parameter int              DATA_W  = 8,
    parameter int              INSTR_W = 16,
    parameter logic [PC_W-1:0] RST_PC  = 8'h00
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
`ifdef CPU_SINGLE_STEP_EN
    input  logic               step,
`endif
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               rf_read_en,
    output logic               rf_write_en,
    output logic [3:0]         rf_read1_addr,
    output logic [3:0]         rf_read2_addr,
    output logic [3:0]         rf_write_addr,
    output logic [DATA_W-1:0]  rf_write_data,
    input  logic [DATA_W-1:0]  rf_read1_data,
    input  logic [DATA_W-1:0]  rf_read2_data,
    output logic [PC_W-1:0]    pc,
    output logic               busy,
    output logic               halted,
    output logic               zero_flag
);

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    state_e              state_r;
    state_e              state_next_s;
    logic [3:0]          op_r;
    logic [7:0]          imm8_r;
    logic                branch_r;
    logic [PC_W-1:0]     pc_r;
    logic [PC_W-1:0]     pc_next_s;
    logic [3:0]          rd1_addr_r;
    logic [3:0]          rd2_addr_r;
    logic [3:0]          wr_addr_r;
    logic [DATA_W-1:0]   wr_data_r;
    logic                zero_flag_r;
    logic                imem_req_r;
    logic                rd_en_r;
    logic                wr_en_r;
    logic                busy_r;
    logic                halted_r;
    logic [DATA_W-1:0]   alu_result_s;
    logic                alu_zero_s;
    logic [3:0]          fetch_op_s;

    assign fetch_op_s = imem_data[OP_HI:OP_LO];

    cpu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op     (op_r),
        .a      (rf_read1_data),
        .b      (rf_read2_data),
        .imm8   (imm8_r),
        .result (alu_result_s),
        .zero   (alu_zero_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_next_s = ST_FETCH;
                else       state_next_s = ST_IDLE;
            end
            ST_FETCH: begin
                if (imem_ack) state_next_s = ST_DECODE;
                else          state_next_s = ST_FETCH;
            end
            ST_DECODE: begin
                if (op_r == OP_HALT) state_next_s = ST_HALT;
                else                 state_next_s = ST_READ;
            end
            ST_READ: state_next_s = ST_EXEC;
            ST_EXEC: state_next_s = ST_WB;
`ifdef CPU_SINGLE_STEP_EN
            ST_WB:   state_next_s = ST_PAUSE;
            ST_PAUSE: begin
                if (step) state_next_s = ST_FETCH;
                else      state_next_s = ST_PAUSE;
            end
`else
            ST_WB:   state_next_s = ST_FETCH;
`endif
            ST_HALT: begin
                if (start) state_next_s = ST_FETCH;
                else       state_next_s = ST_HALT;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Next PC at write-back: jump, taken branch, or sequential (wraps)
    always_comb begin
        pc_next_s = pc_r + PC_ONE;
        case (op_r)
            OP_JMP: pc_next_s = PC_W'(imm8_r);
            OP_BEQZ: begin
                if (branch_r) pc_next_s = PC_W'(imm8_r);
                else          pc_next_s = pc_r + PC_ONE;
            end
            default: pc_next_s = pc_r + PC_ONE;
        endcase
    end

    // Datapath registers: instruction fields, rf addresses, result, flags, pc
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r        <= 4'h0;
            imm8_r      <= 8'h00;
            branch_r    <= 1'b0;
            pc_r        <= RST_PC;
            rd1_addr_r  <= 4'h0;
            rd2_addr_r  <= 4'h0;
            wr_addr_r   <= 4'h0;
            wr_data_r   <= {DATA_W{1'b0}};
            zero_flag_r <= 1'b0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    // Addresses are taken straight from the fetched word so
                    // they are already stable during DECODE, one cycle
                    // ahead of the read strobe.
                    if (imem_ack) begin
                        op_r       <= fetch_op_s;
                        imm8_r     <= imem_data[IMM_HI:IMM_LO];
                        rd1_addr_r <= (fetch_op_s == OP_BEQZ) ? imem_data[RD_HI:RD_LO]
                                                              : imem_data[RS1_HI:RS1_LO];
                        rd2_addr_r <= imem_data[RS2_HI:RS2_LO];
                        wr_addr_r  <= imem_data[RD_HI:RD_LO];
                    end
                end
                ST_EXEC: begin
                    wr_data_r <= alu_result_s;
                    branch_r  <= (rf_read1_data == {DATA_W{1'b0}});
                    if (op_sets_zero(op_r)) zero_flag_r <= alu_zero_s;
                end
                ST_WB: pc_r <= pc_next_s;
                ST_HALT: begin
                    if (start) pc_r <= RST_PC;
                end
                default: ;
            endcase
        end
    end

    // Strobes and status are decoded from the state being entered so that
    // they are registered and line up exactly with that state
    always_ff @(posedge clk) begin
        if (rst) begin
            imem_req_r <= 1'b0;
            rd_en_r    <= 1'b0;
            wr_en_r    <= 1'b0;
            busy_r     <= 1'b0;
            halted_r   <= 1'b0;
        end else begin
            imem_req_r <= (state_next_s == ST_FETCH);
            rd_en_r    <= (state_next_s == ST_READ);
            wr_en_r    <= (state_next_s == ST_WB) && op_writes_rd(op_r);
            busy_r     <= !((state_next_s == ST_IDLE) || (state_next_s == ST_HALT));
            halted_r   <= (state_next_s == ST_HALT);
        end
    end

    assign imem_req      = imem_req_r;
    assign imem_addr     = pc_r;
    assign rf_read_en    = rd_en_r;
    assign rf_write_en   = wr_en_r;
    assign rf_read1_addr = rd1_addr_r;
    assign rf_read2_addr = rd2_addr_r;
    assign rf_write_addr = wr_addr_r;
    assign rf_write_data = wr_data_r;
    assign pc            = pc_r;
    assign busy          = busy_r;
    assign halted        = halted_r;
    assign zero_flag     = zero_flag_r;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_seq_ctrl
// Self-checking bench for cpu_seq_ctrl. An instruction-level model of the
// CPU predicts the fetch address sequence and every register write; a
// monitor compares these against the DUT as handshakes and strobes occur.
// The bench also provides the instruction memory (with stalls) and the
// 16x8 register file.
// ---------------------------------------------------------------------------
module tb_cpu_seq_ctrl;

`ifdef CPU_SINGLE_STEP_EN
    localparam int CYC_PER = 6;
`else
    localparam int CYC_PER = 5;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        step = 1'b1;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_data = 16'h0000;
    logic        rf_read_en, rf_write_en;
    logic [3:0]  rf_read1_addr, rf_read2_addr, rf_write_addr;
    logic [7:0]  rf_write_data;
    logic [7:0]  rf_read1_data = 8'h00;
    logic [7:0]  rf_read2_data = 8'h00;
    logic [7:0]  pc;
    logic        busy, halted, zero_flag;

    always #5 clk = ~clk;

    cpu_seq_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
`ifdef CPU_SINGLE_STEP_EN
        .step          (step),
`endif
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_data     (imem_data),
        .rf_read_en    (rf_read_en),
        .rf_write_en   (rf_write_en),
        .rf_read1_addr (rf_read1_addr),
        .rf_read2_addr (rf_read2_addr),
        .rf_write_addr (rf_write_addr),
        .rf_write_data (rf_write_data),
        .rf_read1_data (rf_read1_data),
        .rf_read2_data (rf_read2_data),
        .pc            (pc),
        .busy          (busy),
        .halted        (halted),
        .zero_flag     (zero_flag)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        int addr;
        int data;
        int z;
    } wr_t;

    int  exp_pc_q [$];
    wr_t exp_wr_q [$];
    int  stall_q [$];
    int  exp_halt_pc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- instruction memory model ----------------
    logic [15:0] imem_mem [256];
    int stall_mode = 0;      // 0 none, 1 random 0..3, 2 fixed 3, 3 never ack
    int k_lim = 1000;        // after this many fetches serve HALT
    int fetch_cnt = 0;
    int wait_left = -1;

    always begin
        @(posedge clk);
        #1;
        imem_ack = 1'b0;
        if (rst) begin
            fetch_cnt = 0;
            wait_left = -1;
        end else if (imem_req) begin
            if (wait_left < 0) begin
                case (stall_mode)
                    0:       wait_left = 0;
                    1:       wait_left = $urandom_range(0, 3);
                    2:       wait_left = 3;
                    default: wait_left = 1000000;
                endcase
                if (stall_mode != 3) stall_q.push_back(wait_left);
            end
            if (wait_left == 0) begin
                imem_ack  = 1'b1;
                imem_data = (fetch_cnt >= k_lim) ? 16'hF000 : imem_mem[imem_addr];
                fetch_cnt++;
                wait_left = -1;
            end else begin
                wait_left--;
            end
        end else begin
            wait_left = -1;
        end
    end

    // ---------------- register file model ----------------
    logic [7:0] rf_regs [16];
    logic [7:0] rf_init [16];
    logic       rf_load = 1'b0;

    always @(posedge clk) begin
        if (rf_load) begin
            for (int i = 0; i < 16; i++) rf_regs[i] <= rf_init[i];
        end else if (rf_write_en) begin
            rf_regs[rf_write_addr] <= rf_write_data;
        end
        if (rf_read_en) begin
            rf_read1_data <= rf_regs[rf_read1_addr];
            rf_read2_data <= rf_regs[rf_read2_addr];
        end
    end

    // ---------------- instruction-level reference model ----------------
    task automatic iss(input int k);
        int r [16];
        int p, z, op, rd, rs1, rs2, imm, v;
        logic [15:0] ins;
        wr_t w;
        for (int i = 0; i < 16; i++) r[i] = int'(rf_init[i]);
        p = 0;
        z = 0;
        for (int n = 0; n <= k; n++) begin
            ins = (n >= k) ? 16'hF000 : imem_mem[p];
            exp_pc_q.push_back(p);
            op  = int'(ins[15:12]);
            rd  = int'(ins[11:8]);
            rs1 = int'(ins[7:4]);
            rs2 = int'(ins[3:0]);
            imm = int'(ins[7:0]);
            if (op == 15) begin
                exp_halt_pc = p;
                break;
            end
            v = -1;
            case (op)
                1: v = (r[rs1] + r[rs2]) % 256;
                2: v = (r[rs1] - r[rs2] + 256) % 256;
                3: v = r[rs1] & r[rs2];
                4: v = r[rs1] | r[rs2];
                5: v = r[rs1] ^ r[rs2];
                6: v = imm;
                7: v = r[rs1];
                default: v = -1;
            endcase
            if (op >= 1 && op <= 5) z = (v == 0) ? 1 : 0;
            if (op == 8)                      p = imm;
            else if (op == 9 && r[rd] == 0)   p = imm;
            else                              p = (p + 1) % 256;
            if (v >= 0) begin
                r[rd] = v;
                w.addr = rd;
                w.data = v;
                w.z    = z;
                exp_wr_q.push_back(w);
            end
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    int  cyc = 0;
    int  last_hs = -1;
    int  st_m;
    int  exp_p;
    wr_t w_m;

    always @(negedge clk) begin
        cyc++;
        if (rst) stall_q.delete();
        if (!busy) last_hs = -1;
        if (imem_req && !imem_ack)
            check("stall_no_strobe", {30'd0, rf_read_en, rf_write_en}, 32'd0);
        if (imem_req && imem_ack) begin
            if (exp_pc_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL fetch_unexpected: fetch at %0h, none expected", imem_addr);
            end else begin
                exp_p = exp_pc_q.pop_front();
                check("fetch_pc", {24'd0, imem_addr}, exp_p);
            end
            st_m = (stall_q.size() != 0) ? stall_q.pop_front() : 0;
            if (last_hs >= 0) check("latency", cyc - last_hs, CYC_PER + st_m);
            last_hs = cyc;
        end
        if (rf_write_en) begin
            if (exp_wr_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL wr_unexpected: addr %0h data %0h, none expected", rf_write_addr, rf_write_data);
            end else begin
                w_m = exp_wr_q.pop_front();
                check("wr_addr", {28'd0, rf_write_addr}, w_m.addr);
                check("wr_data", {24'd0, rf_write_data}, w_m.data);
                check("wr_zero_flag", {31'd0, zero_flag}, w_m.z);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        exp_pc_q.delete();
        exp_wr_q.delete();
    endtask

    task automatic check_idle(input string nm);
        check({nm, "_pc"},       {24'd0, pc}, 32'h00);
        check({nm, "_busy"},     {31'd0, busy}, 32'd0);
        check({nm, "_halted"},   {31'd0, halted}, 32'd0);
        check({nm, "_req"},      {31'd0, imem_req}, 32'd0);
        check({nm, "_strobes"},  {30'd0, rf_read_en, rf_write_en}, 32'd0);
        check({nm, "_zf"},       {31'd0, zero_flag}, 32'd0);
        check({nm, "_rf_addrs"}, {20'd0, rf_read1_addr, rf_read2_addr, rf_write_addr}, 32'd0);
        check({nm, "_wdata"},    {24'd0, rf_write_data}, 32'd0);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic run_prog(input int k, input int mode);
        do_reset();
        @(negedge clk) rf_load = 1'b1;
        @(negedge clk) rf_load = 1'b0;
        k_lim      = k;
        stall_mode = mode;
        iss(k);
        pulse_start();
    endtask

    task automatic wait_halt(input string nm);
        int n = 0;
        while (!halted && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_halted"}, {31'd0, halted}, 32'd1);
        check({nm, "_busy"}, {31'd0, busy}, 32'd0);
        check({nm, "_halt_pc"}, {24'd0, pc}, exp_halt_pc);
        check({nm, "_pc_left"}, exp_pc_q.size(), 32'd0);
        check({nm, "_wr_left"}, exp_wr_q.size(), 32'd0);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) imem_mem[i] = 16'h0000;
        for (int i = 0; i < 16; i++) rf_init[i] = 8'h00;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        clear_mem();
        do_reset();
        check_idle("reset");

        // LDI/LDI then ADD, then ADD with wrap to zero, then HALT
        imem_mem[0] = 16'h6105;
        imem_mem[1] = 16'h6203;
        imem_mem[2] = 16'h1312;
        imem_mem[3] = 16'h61FF;
        imem_mem[4] = 16'h6201;
        imem_mem[5] = 16'h1312;
        imem_mem[6] = 16'hF000;
        run_prog(1000, 0);
        repeat (2 * CYC_PER) @(negedge clk);
        check("two_instr_pc", {24'd0, pc}, 32'h02);
        check("two_instr_r1", {24'd0, rf_regs[1]}, 32'h05);
        check("two_instr_r2", {24'd0, rf_regs[2]}, 32'h03);
        wait_halt("prog_alu");
        repeat (4) begin
            @(negedge clk);
            check("halt_no_req", {31'd0, imem_req}, 32'd0);
        end

        // Restart from HALT into a memory that never acknowledges
        stall_mode = 3;
        pulse_start();
        check("resume_pc", {24'd0, pc}, 32'h00);
        check("resume_req", {31'd0, imem_req}, 32'd1);
        check("resume_busy", {31'd0, busy}, 32'd1);
        check("resume_halted", {31'd0, halted}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("stall_req_held", {31'd0, imem_req}, 32'd1);
        end
        do_reset();
        check_idle("rst_in_fetch");

        // BEQZ taken, JMP from FF
        clear_mem();
        imem_mem[8'h00] = 16'h6000;
        imem_mem[8'h01] = 16'h9040;
        imem_mem[8'h40] = 16'h80FF;
        imem_mem[8'hFF] = 16'h8010;
        imem_mem[8'h10] = 16'hF000;
        run_prog(1000, 1);
        wait_halt("prog_branch");

        // NOP at FF wraps pc to 00
        clear_mem();
        imem_mem[8'h00] = 16'h80FF;
        imem_mem[8'hFF] = 16'h0000;
        run_prog(2, 2);
        wait_halt("prog_wrap");

        // Reset while in READ
        for (int i = 0; i < 256; i++) imem_mem[i] = 16'($urandom);
        for (int i = 0; i < 16; i++) rf_init[i] = 8'($urandom);
        imem_mem[0] = 16'h6155;
        run_prog(30, 1);
        n = 0;
        while (!rf_read_en && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("read_seen", {31'd0, rf_read_en}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_idle("rst_mid_read");
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_quiet", {29'd0, imem_req, rf_read_en, rf_write_en}, 32'd0);
        end
        exp_pc_q.delete();
        exp_wr_q.delete();

        // Random programs
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 256; i++) imem_mem[i] = 16'($urandom);
            for (int i = 0; i < 16; i++) rf_init[i] = 8'($urandom);
            run_prog($urandom_range(8, 40), 1);
            wait_halt("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
